lfsr_arbiter: RTL and testbench

LFSR_ARBITER -- requirements
Module: lfsr_arbiter

---
 rtl/lfsr_arbiter_if.sv | 25 ++
 rtl/lfsr_arbiter.sv | 117 +++++++++++
 tb/tb_lfsr_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_arbiter_if.sv
// Handshake bundle between the LFSR burst arbiter and its two requesters.
// slave = arbiter side, master = requester/stimulus side.
interface lfsr_arbiter_if;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       seed_val;
  logic [7:0] seed;
  logic [1:0] gnt;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic       busy;

  modport master (
    output req, len0, len1, seed_val, seed, dout_ready,
    input  gnt, dout, dout_valid, dout_last, busy
  );

  modport slave (
    input  req, len0, len1, seed_val, seed, dout_ready,
    output gnt, dout, dout_valid, dout_last, busy
  );
endinterface

// File: rtl/lfsr_arbiter.sv
// Round-robin two-requester arbiter streaming LFSR bursts; first beat one cycle after the IDLE decision.
// Beats hold while dout_ready is low; the LFSR advances only on accepted beats, one IDLE bubble between bursts.
module lfsr_arbiter (
  input  logic           clk,
  input  logic           rst,
  lfsr_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEED   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] r;
  logic [7:0] r_nxt;
  logic [4:0] cnt;
  logic       last_srv;
  logic       win;
  logic [3:0] win_len;
  logic [4:0] win_cnt;
  logic       accept;
  logic [1:0] gnt_q;
  logic [7:0] dout_q;
  logic       valid_q;
  logic       last_q;
  logic       busy_q;

  assign r_nxt  = {r[6:0], (r[7] ~^ r[5]) ^ (r[4] ~^ r[3])};
  assign accept = valid_q & bus.dout_ready;

  // Contention goes to whoever was not served last; a lone request wins outright.
  always_comb begin
    win = bus.req[1];
    if (bus.req == 2'b11) begin
      win = ~last_srv;
    end
    win_len = win ? bus.len1 : bus.len0;
    win_cnt = (win_len == 4'd0) ? 5'd16 : {1'b0, win_len};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.seed_val) begin
          state_nxt = SEED;
        end else if (bus.req != 2'b00) begin
          state_nxt = STREAM;
        end
      end
      SEED:    state_nxt = IDLE;
      STREAM: begin
        if (accept && (cnt == 5'd1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      r        <= 8'h01;
      cnt      <= 5'd0;
      last_srv <= 1'b1;
      gnt_q    <= 2'b00;
      dout_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (!bus.seed_val && (bus.req != 2'b00)) begin
            gnt_q    <= win ? 2'b10 : 2'b01;
            last_srv <= win;
            cnt      <= win_cnt;
            dout_q   <= r;
            valid_q  <= 1'b1;
            last_q   <= (win_cnt == 5'd1);
          end
        end
        SEED: begin
          // All-zero would lock the XNOR feedback, so it is replaced by 1.
          r <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        end
        STREAM: begin
          if (accept) begin
            r   <= r_nxt;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
              gnt_q   <= 2'b00;
              dout_q  <= 8'h00;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              dout_q <= r_nxt;
              last_q <= (cnt == 5'd2);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_last  = last_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Bench for lfsr_arbiter: directed vector table, reset-abort sequence, and random traffic
// compared against a burst-level reference model.
module tb_lfsr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_arbiter_if bus ();
  lfsr_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         rs;
    logic [1:0] req;
    logic [3:0] l0;
    logic [3:0] l1;
    logic       rdy;
    logic       sv;
    logic [7:0] seed;
    logic [1:0] gnt;
    logic [7:0] dout;
    logic       vld;
    logic       last;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rs, logic [1:0] req, logic [3:0] l0, logic [3:0] l1,
                              logic rdy, logic sv, logic [7:0] seed, logic [1:0] gnt,
                              logic [7:0] dout, logic vld, logic last, logic busy);
    vec_t v;
    v.rs = rs; v.req = req; v.l0 = l0; v.l1 = l1; v.rdy = rdy; v.sv = sv; v.seed = seed;
    v.gnt = gnt; v.dout = dout; v.vld = vld; v.last = last; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] req, input logic [3:0] l0, input logic [3:0] l1,
                        input logic rdy, input logic sv, input logic [7:0] seed);
    bus.req = req; bus.len0 = l0; bus.len1 = l1;
    bus.dout_ready = rdy; bus.seed_val = sv; bus.seed = seed;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] gnt, input logic [7:0] dout,
                            input logic vld, input logic last, input logic busy);
    chk({tag, " gnt"}, 32'(bus.gnt), 32'(gnt));
    chk({tag, " valid"}, 32'(bus.dout_valid), 32'(vld));
    chk({tag, " last"}, 32'(bus.dout_last), 32'(last));
    chk({tag, " busy"}, 32'(bus.busy), 32'(busy));
    if (vld) chk({tag, " dout"}, 32'(bus.dout), 32'(dout));
  endtask

  // Reset is released half a cycle before the next rising edge.
  task automatic do_reset();
    set_in(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic fb;
    fb = (v[7] == v[5]) ^ (v[4] == v[3]);
    return {v[6:0], fb};
  endfunction

  logic [7:0] m_r;
  logic [7:0] m_q[$];
  logic       m_last;
  logic       m_seeding;
  logic [1:0] m_gnt;

  task automatic model_init();
    m_r = 8'h01; m_q.delete(); m_last = 1'b1; m_seeding = 1'b0; m_gnt = 2'b00;
  endtask

  // Burst-level view: a granted burst enqueues all its beat values up front.
  task automatic model_step(input logic [1:0] req, input logic [3:0] l0, input logic [3:0] l1,
                            input logic rdy, input logic sv, input logic [7:0] seed);
    int who;
    int n;
    logic [7:0] v;
    if (m_q.size() > 0) begin
      if (rdy) begin
        void'(m_q.pop_front());
        m_r = lfsr_step(m_r);
        if (m_q.size() == 0) m_gnt = 2'b00;
      end
    end else if (m_seeding) begin
      m_r = (seed == 8'h00) ? 8'h01 : seed;
      m_seeding = 1'b0;
    end else if (sv) begin
      m_seeding = 1'b1;
    end else if (req != 2'b00) begin
      if (req == 2'b11) who = (m_last == 1'b0) ? 1 : 0;
      else              who = (req == 2'b10) ? 1 : 0;
      n = (who == 1) ? int'(l1) : int'(l0);
      if (n == 0) n = 16;
      v = m_r;
      for (int i = 0; i < n; i++) begin
        m_q.push_back(v);
        v = lfsr_step(v);
      end
      m_last = (who == 1);
      m_gnt  = (who == 1) ? 2'b10 : 2'b01;
    end
  endtask

  initial begin
    // single beat
    tbl.push_back(mk(1, 2'b01, 4'd1, 4'd0, 1, 0, 8'h00, 2'b01, 8'h01, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    // four-beat sequence, req dropped mid-burst, then next burst from 8'h11
    tbl.push_back(mk(1, 2'b01, 4'd4, 4'd0, 1, 0, 8'h00, 2'b01, 8'h01, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd4, 4'd0, 1, 0, 8'h00, 2'b01, 8'h02, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd4, 4'd0, 1, 0, 8'h00, 2'b01, 8'h04, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd4, 4'd0, 1, 0, 8'h00, 2'b01, 8'h08, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd4, 4'd0, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4'd1, 4'd0, 1, 0, 8'h00, 2'b01, 8'h11, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    // round robin, both requesting
    tbl.push_back(mk(1, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b01, 8'h01, 1, 0, 1));
    tbl.push_back(mk(0, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b01, 8'h02, 1, 1, 1));
    tbl.push_back(mk(0, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b10, 8'h04, 1, 0, 1));
    tbl.push_back(mk(0, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b10, 8'h08, 1, 1, 1));
    tbl.push_back(mk(0, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b01, 8'h11, 1, 0, 1));
    tbl.push_back(mk(0, 2'b11, 4'd2, 4'd2, 1, 0, 8'h00, 2'b01, 8'h23, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd2, 4'd2, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 4'd2, 4'd2, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    // backpressure, len0 changed mid-burst
    tbl.push_back(mk(1, 2'b01, 4'd3, 4'd0, 1, 0, 8'h00, 2'b01, 8'h01, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd3, 4'd0, 0, 0, 8'h00, 2'b01, 8'h01, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 0, 0, 8'h00, 2'b01, 8'h01, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 0, 0, 8'h00, 2'b01, 8'h01, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 1, 0, 8'h00, 2'b01, 8'h02, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 1, 0, 8'h00, 2'b01, 8'h04, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 0, 0, 8'h00, 2'b01, 8'h04, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd0, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    // seed beats a simultaneous request; zero seed; seed_val ignored in STREAM
    tbl.push_back(mk(1, 2'b10, 4'd0, 4'd1, 1, 1, 8'hA5, 2'b00, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 2'b10, 4'd0, 4'd1, 1, 0, 8'hA5, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 4'd0, 4'd1, 1, 0, 8'hA5, 2'b10, 8'hA5, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd0, 4'd1, 1, 0, 8'hA5, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 4'd0, 4'd1, 1, 1, 8'h00, 2'b00, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd0, 4'd1, 1, 0, 8'h00, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4'd2, 4'd1, 1, 0, 8'h00, 2'b01, 8'h01, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 4'd2, 4'd1, 1, 1, 8'h55, 2'b01, 8'h02, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd2, 4'd1, 1, 0, 8'h55, 2'b00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 4'd1, 4'd1, 1, 0, 8'h55, 2'b01, 8'h04, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 4'd1, 4'd1, 1, 0, 8'h55, 2'b00, 8'h00, 0, 0, 0));

    // reset state
    set_in(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset dout", 32'(bus.dout), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rs) do_reset();
      set_in(tbl[i].req, tbl[i].l0, tbl[i].l1, tbl[i].rdy, tbl[i].sv, tbl[i].seed);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].dout, tbl[i].vld, tbl[i].last, tbl[i].busy);
    end

    // abort a 16-beat burst during beat 3
    do_reset();
    set_in(2'b01, 4'd0, 4'd0, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_outs("abort b1", 2'b01, 8'h01, 1'b1, 1'b0, 1'b1);
    set_in(2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_outs("abort b2", 2'b01, 8'h02, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_outs("abort b3", 2'b01, 8'h04, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    #2;
    check_outs("abort async", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("abort async dout", 32'(bus.dout), 32'h0);
    set_in(2'b01, 4'd1, 4'd0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outs("abort restart", 2'b01, 8'h01, 1'b1, 1'b1, 1'b1);
    set_in(2'b00, 4'd1, 4'd0, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_outs("abort gap", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

    // random traffic against the model
    do_reset();
    model_init();
    for (int c = 0; c < 1500; c++) begin
      logic [1:0] rq;
      logic [3:0] a;
      logic [3:0] b;
      logic       rd;
      logic       sv;
      logic [7:0] sd;
      rq = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      b  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      rd = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 9) == 0);
      sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      set_in(rq, a, b, rd, sv, sd);
      @(posedge clk); #1;
      model_step(rq, a, b, rd, sv, sd);
      check_outs($sformatf("rand%0d", c), m_gnt, (m_q.size() > 0) ? m_q[0] : 8'h00,
                 m_q.size() > 0, m_q.size() == 1, (m_q.size() > 0) || m_seeding);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
